b2_serial_incrementer: RTL and testbench
========================================

Name: b2_serial_incrementer

Overview:
- Bit-serial N-bit incrementer: computes X + CIN one bit per clock, LSB first.
- Built around a single base-2 half-adder cell with a registered carry loop.
- Sits directly upstream of the half-adder cell: it sequences operand bits and carry into the cell each cycle, captures the cell's sum and carry-out, and collects the result.
- Start/end handshake uses soc/eoc, so it can be driven by a controller or testbench FSM.

Parameters:
- N, 8, operand/result width in bits; legal range N >= 1.

Ports:
- clock, input, 1, system clock, rising-edge active
- reset_, input, 1, asynchronous active-low reset
- soc, input, 1, start of conversion; request to begin an increment
- x, input, N, operand; sampled only at the accepting edge
- cin, input, 1, carry-in (increment amount, 0 or 1); sampled with x
- eoc, output, 1, end of conversion; 1 = idle/result valid, 0 = busy
- s, output, N, result X + CIN modulo 2^N
- cout, output, 1, final carry-out of the MSB position

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; clock port is clock, reset port is reset_.
- Reset (reset_=0, immediate, independent of clock):
  - state=IDLE, eoc=1, s=0, cout=0.
  - Internal operand shift register, result shift register, carry flop and bit counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - eoc=1.
  - On a rising edge with soc=1: load operand register <= x, carry flop <= cin, counter <= N, result register <= 0; go to RUN.
  - soc=0: stay in IDLE.
- RUN:
  - eoc=0; exactly N clock edges.
  - Each edge, half-adder cell inputs are operand register bit 0 and the carry flop.
  - Sum bit = bit0 XOR carry; it is shifted into the result register MSB (result register shifts right).
  - Carry flop <= bit0 AND carry; operand register shifts right; counter decrements.
  - On the edge where the counter goes 1 -> 0:
    - s <= completed result (including the sum bit from this edge);
    - cout <= the carry produced on this edge;
    - go to DONE.
  - soc and x are ignored during RUN.
- DONE:
  - eoc=1; s and cout hold their values.
  - soc=1: stay in DONE, with no restart while soc is still high from the previous request.
  - soc=0: go to IDLE.
- Latency:
  - soc=1 sampled at edge T0 -> eoc falls after T0.
  - eoc rises after edge T0+N; s and cout are valid from that same edge.
  - Busy for exactly N cycles, independent of data (no early-out).
- s and cout change only at the completion edge or on reset; they are never updated bit by bit while eoc=0.
- Wrap-around: x = 2^N-1 with cin=1 gives s=0, cout=1. Result is always modulo 2^N.
- cin=0: s=x, cout=0 (pass-through, still N cycles).
- N=1: RUN lasts one edge; s=x^cin, cout=x&cin.
- Reset mid-RUN: operation aborted, all outputs return to reset values, no partial result ever reaches s.
- Back-to-back requests: a new request needs soc=0 seen in DONE, then soc=1 in IDLE. Minimum period is N+2 cycles.

Test Plan:
- N=8, reset_ pulsed low mid-cycle with no clock -> eoc=1, s=0x00, cout=0 immediately.
- x=0x00, cin=1, soc=1 for one edge -> eoc=0 for 8 cycles, then eoc=1, s=0x01, cout=0.
- x=0xFF, cin=1 -> after 8 busy cycles s=0x00, cout=1; x=0x7F, cin=1 -> s=0x80, cout=0.
- x=0x5A, cin=0; x driven to 0xFF at busy cycle 3 -> s=0x5A, cout=0; s stays at its previous value until the completion edge.
- soc held high through completion -> stays in DONE with eoc=1 and no second run; soc dropped for one cycle then raised -> a new 8-cycle run starts.
- reset_=0 at busy cycle 4 of x=0xFF, cin=1 -> eoc=1, s=0, cout=0; a subsequent x=0x03, cin=1 request completes with s=0x04.

Source files
------------

// File: rtl/b2_serial_incrementer.sv
// b2_serial_incrementer: bit-serial X + CIN through one half-adder cell, LSB first.
// Result and final carry are published only on the completion edge.
module b2_serial_incrementer #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         soc,
    input  logic [N-1:0] x,
    input  logic         cin,
    output logic         eoc,
    output logic [N-1:0] s,
    output logic         cout
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [N-1:0]  opr, res, res_next;
    logic [CW-1:0] cnt;
    logic          carry, sum, carry_out, last;

    always_comb begin
        sum        = opr[0] ^ carry;
        carry_out  = opr[0] & carry;
        res_next   = (res >> 1) | (N'(sum) << (N - 1));
        last       = cnt == CW'(1);
        state_next = state;
        state_next = (state == IDLE) ? (soc ? RUN : IDLE) :
                     (state == RUN)  ? (last ? DONE : RUN) :
                                       (soc ? DONE : IDLE);
    end

    assign eoc = state != RUN;

    // s/cout are loaded only when the last bit lands, never bit by bit
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            opr   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && soc) begin
                opr   <= x;
                carry <= cin;
                cnt   <= CW'(N);
                res   <= '0;
            end else if (state == RUN) begin
                opr   <= opr >> 1;
                carry <= carry_out;
                cnt   <= cnt - CW'(1);
                res   <= res_next;
                if (last) begin
                    s    <= res_next;
                    cout <= carry_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_b2_serial_incrementer.sv
// tb_b2_serial_incrementer: random and directed increments checked every cycle
// against an arithmetic model of the request/busy/done timing.
module tb_b2_serial_incrementer;
    localparam int N = 8;

    logic         clock = 1'b0;
    logic         reset_;
    logic         soc = 1'b0;
    logic [N-1:0] x = '0;
    logic         cin = 1'b0;
    logic         eoc;
    logic [N-1:0] s;
    logic         cout;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    b2_serial_incrementer #(.N(N)) dut (
        .clock(clock), .reset_(reset_), .soc(soc), .x(x), .cin(cin),
        .eoc(eoc), .s(s), .cout(cout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request costs N busy edges, then the result is x+cin; after
    // completion soc must be seen low once before another request is taken.
    int           m_left;
    bit           m_need_low;
    logic [N:0]   m_sum;
    logic [N-1:0] m_s;
    logic         m_cout;

    always @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            m_left = 0; m_need_low = 0; m_s = '0; m_cout = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                {m_cout, m_s} = m_sum;
                m_need_low = 1;
            end
        end else if (m_need_low) begin
            m_need_low = soc;
        end else if (soc) begin
            m_sum  = {1'b0, x} + (N+1)'(cin);
            m_left = N;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("eoc", 32'(eoc), 32'(m_left == 0));
            chk("s", 32'(s), 32'(m_s));
            chk("cout", 32'(cout), 32'(m_cout));
        end
    end

    task automatic do_op(input logic [N-1:0] xv, input logic cv, input bit noisy, output int busy);
        @(posedge clock); #2;
        soc = 1'b0;
        @(posedge clock); #2;
        soc = 1'b1; x = xv; cin = cv;
        @(posedge clock); #2;
        soc = 1'b0;
        busy = 0;
        while (!eoc && busy < 40) begin
            if (noisy) begin
                x = N'($urandom);
                cin = 1'($urandom);
                soc = 1'($urandom);
            end
            @(posedge clock); #2;
            busy++;
        end
        soc = 1'b0;
        chk("busy_cycles", 32'(busy), 32'(N));
        chk("op_sum", 32'({cout, s}), 32'({1'b0, xv} + (N+1)'(cv)));
    endtask

    initial begin
        int busy;
        reset_ = 1'b0;
        #12 reset_ = 1'b1;
        chk_en = 1'b1;
        @(posedge clock); #2;

        // asynchronous reset between edges
        reset_ = 1'b0; #1;
        chk("async_rst_eoc", 32'(eoc), 32'h1);
        chk("async_rst_s", 32'(s), 32'h0);
        chk("async_rst_cout", 32'(cout), 32'h0);
        #1 reset_ = 1'b1;

        do_op(8'h00, 1'b1, 1'b0, busy);
        chk("lit_00p1", 32'({cout, s}), 32'h001);
        do_op(8'hFF, 1'b1, 1'b0, busy);
        chk("lit_ffp1", 32'({cout, s}), 32'h100);
        do_op(8'h7F, 1'b1, 1'b0, busy);
        chk("lit_7fp1", 32'({cout, s}), 32'h080);

        // operand changes during the run must not matter
        @(posedge clock); #2 soc = 1'b1; x = 8'h5A; cin = 1'b0;
        @(posedge clock); #2 soc = 1'b0;
        repeat (3) begin @(posedge clock); #2; end
        x = 8'hFF;
        repeat (5) begin @(posedge clock); #2; end
        chk("lit_5a_eoc", 32'(eoc), 32'h1);
        chk("lit_5a", 32'({cout, s}), 32'h05A);

        // soc held through completion: no restart
        @(posedge clock); #2 soc = 1'b1; x = 8'h10; cin = 1'b1;
        repeat (14) begin @(posedge clock); #2; end
        chk("held_soc_eoc", 32'(eoc), 32'h1);
        chk("held_soc_s", 32'(s), 32'h11);
        soc = 1'b0; x = 8'h20;
        @(posedge clock); #2 soc = 1'b1;
        @(posedge clock); #2 soc = 1'b0;
        chk("restart_busy", 32'(eoc), 32'h0);
        repeat (8) begin @(posedge clock); #2; end
        chk("restart_s", 32'({cout, s}), 32'h021);

        // reset mid-run
        @(posedge clock); #2 soc = 1'b1; x = 8'hFF; cin = 1'b1;
        @(posedge clock); #2 soc = 1'b0;
        repeat (4) begin @(posedge clock); #2; end
        reset_ = 1'b0; #1;
        chk("midrun_rst_eoc", 32'(eoc), 32'h1);
        chk("midrun_rst_s", 32'({cout, s}), 32'h0);
        #1 reset_ = 1'b1;
        do_op(8'h03, 1'b1, 1'b0, busy);
        chk("lit_03p1", 32'({cout, s}), 32'h004);

        for (int i = 0; i < 30; i++)
            do_op(N'($urandom), 1'($urandom), 1'($urandom), busy);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
